fifo_rd_packer: RTL and testbench

- Read-side consumer of the asynchronous FIFO, clocked in the FIFO read domain.
- Pops DATA_WIDTH words through the FIFO read port (rd_en, empty_out, rd_data with a one-cycle output register).
- Packs PACK consecutive words into one wide beat and presents it on a valid/ready stream.
- A flush request emits a partial beat with a lane-keep mask.

---
 rtl/fifo_rd_packer.sv | 123 ++++++++++++
 tb/tb_fifo_rd_packer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: pops DATA_WIDTH words and packs PACK of them into one
// valid/ready beat, with a flush that emits a partial beat under a lane-keep mask.
module fifo_rd_packer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PACK       = 4
) (
    input  logic                       rd_clk,
    input  logic                       rst_glb,
    input  logic                       fifo_empty,
    output logic                       fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]      fifo_rd_data,
    input  logic                       flush,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [PACK*DATA_WIDTH-1:0] m_data,
    output logic [PACK-1:0]            m_keep,
    output logic                       busy
);

    localparam int unsigned CntW = $clog2(PACK + 1);
    localparam int unsigned OutW = PACK * DATA_WIDTH;

    typedef enum logic [0:0] {StFill, StDrain} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] lane_cnt_q, lane_cnt_d;
    logic            pend_q, pend_d;
    logic [OutW-1:0] acc_q, acc_d;
    logic [OutW-1:0] m_data_q, m_data_d;
    logic [PACK-1:0] m_keep_q, m_keep_d;
    logic            m_valid_q, m_valid_d;

    logic            free, full, xfer, part, rd_en;
    logic [CntW:0]   fill_lvl;
    logic [CntW-1:0] cap_idx;

    always_comb begin
        free     = !m_valid_q || m_ready;
        full     = lane_cnt_q == CntW'(PACK);
        xfer     = full && free;
        part     = (state_q == StDrain) && !pend_q && (lane_cnt_q != '0) && !full && free;
        fill_lvl = {1'b0, lane_cnt_q} + {{CntW{1'b0}}, pend_q};
        rd_en    = !rst_glb && !fifo_empty && (state_q == StFill) &&
                   ((fill_lvl < (CntW + 1)'(PACK)) || (full && !pend_q && xfer));
    end

    always_comb begin
        pend_d     = rd_en;
        acc_d      = acc_q;
        lane_cnt_d = lane_cnt_q;
        cap_idx    = lane_cnt_q;
        m_data_d   = m_data_q;
        m_keep_d   = m_keep_q;
        m_valid_d  = m_valid_q;
        state_d    = state_q;

        if (m_ready) begin
            m_valid_d = 1'b0;
        end

        // Emitting clears the accumulator so unused lanes of a later partial beat read zero.
        if (xfer || part) begin
            m_data_d   = acc_q;
            m_valid_d  = 1'b1;
            acc_d      = '0;
            lane_cnt_d = '0;
            cap_idx    = '0;
            for (int unsigned k = 0; k < PACK; k++) begin
                m_keep_d[k] = xfer || (CntW'(k) < lane_cnt_q);
            end
        end

        if (pend_q) begin
            for (int unsigned k = 0; k < PACK; k++) begin
                if (cap_idx == CntW'(k)) begin
                    acc_d[k*DATA_WIDTH +: DATA_WIDTH] = fifo_rd_data;
                end
            end
            lane_cnt_d = cap_idx + CntW'(1);
        end

        unique case (state_q)
            StFill: begin
                if (flush) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!pend_q && ((lane_cnt_q == '0) || xfer || part)) begin
                    state_d = StFill;
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (rst_glb) begin
            state_q    <= StFill;
            lane_cnt_q <= '0;
            pend_q     <= 1'b0;
            acc_q      <= '0;
            m_data_q   <= '0;
            m_keep_q   <= '0;
            m_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_cnt_q <= lane_cnt_d;
            pend_q     <= pend_d;
            acc_q      <= acc_d;
            m_data_q   <= m_data_d;
            m_keep_q   <= m_keep_d;
            m_valid_q  <= m_valid_d;
        end
    end

    assign fifo_rd_en = rd_en;
    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_keep     = m_keep_q;
    assign busy       = (lane_cnt_q != '0) || pend_q || m_valid_q || (state_q == StDrain);

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: behavioural FIFO with registered read data,
// beat monitor, and hand-computed expected beats.
module tb_fifo_rd_packer;

    localparam int unsigned DW = 8;
    localparam int unsigned PK = 4;

    logic           rd_clk = 1'b0;
    logic           rst_glb = 1'b1;
    logic           fifo_empty;
    logic           fifo_rd_en;
    logic [DW-1:0]  fifo_rd_data = '0;
    logic           flush = 1'b0;
    logic           m_valid;
    logic           m_ready = 1'b1;
    logic [PK*DW-1:0] m_data;
    logic [PK-1:0]  m_keep;
    logic           busy;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_rd_packer #(
        .DATA_WIDTH(DW),
        .PACK      (PK)
    ) dut (
        .rd_clk      (rd_clk),
        .rst_glb     (rst_glb),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_rd_data(fifo_rd_data),
        .flush       (flush),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_keep      (m_keep),
        .busy        (busy)
    );

    always #5 rd_clk = ~rd_clk;

    logic [DW-1:0] mem [0:63];
    int            wr_ptr   = 0;
    int            rd_ptr   = 0;
    int            beat_cnt = 0;
    int            bad_pop  = 0;
    logic [31:0]   beat_data [0:31];
    logic [3:0]    beat_keep [0:31];

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge rd_clk) begin
        if (fifo_rd_en === 1'b1) begin
            if (fifo_empty) begin
                bad_pop <= bad_pop + 1;
            end else begin
                fifo_rd_data <= mem[rd_ptr[5:0]];
                rd_ptr       <= rd_ptr + 1;
            end
        end
        if (m_valid === 1'b1 && m_ready && beat_cnt < 32) begin
            beat_data[beat_cnt[4:0]] <= m_data;
            beat_keep[beat_cnt[4:0]] <= m_keep;
            beat_cnt                 <= beat_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] v);
        mem[wr_ptr[5:0]] = v;
        wr_ptr++;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge rd_clk);
    endtask

    task automatic wait_beats(input string tag, input int target, input int budget);
        int i = 0;
        while (beat_cnt < target && i < budget) begin
            @(negedge rd_clk);
            i++;
        end
        check_eq(tag, 64'(beat_cnt), 64'(target));
    endtask

    initial begin
        for (int i = 0; i < 8; i++) push(8'(i));

        // Reset held 3 cycles with data waiting.
        for (int i = 0; i < 3; i++) begin
            @(negedge rd_clk);
            check_eq("rst_rd_en", 64'(fifo_rd_en), 64'd0);
            check_eq("rst_m_valid", 64'(m_valid), 64'd0);
            check_eq("rst_m_keep", 64'(m_keep), 64'd0);
            check_eq("rst_busy", 64'(busy), 64'd0);
        end
        check_eq("rst_m_data", 64'(m_data), 64'd0);
        check_eq("rst_no_pops", 64'(rd_ptr), 64'd0);
        rst_glb = 1'b0;
        #1;
        check_eq("release_pop", 64'(fifo_rd_en), 64'd1);

        // Streaming.
        wait_beats("stream_beats", 2, 40);
        cycles(3);
        check_eq("stream_beat0", 64'(beat_data[0]), 64'h03020100);
        check_eq("stream_keep0", 64'(beat_keep[0]), 64'hF);
        check_eq("stream_beat1", 64'(beat_data[1]), 64'h07060504);
        check_eq("stream_keep1", 64'(beat_keep[1]), 64'hF);
        check_eq("stream_pops", 64'(rd_ptr), 64'd8);
        check_eq("stream_rd_en_empty", 64'(fifo_rd_en), 64'd0);
        check_eq("stream_idle", 64'(busy), 64'd0);

        // Backpressure.
        m_ready = 1'b0;
        for (int i = 0; i < 12; i++) push(8'(i));
        cycles(20);
        check_eq("bp_valid", 64'(m_valid), 64'd1);
        check_eq("bp_data", 64'(m_data), 64'h03020100);
        check_eq("bp_keep", 64'(m_keep), 64'hF);
        check_eq("bp_pops", 64'(rd_ptr), 64'd16);
        check_eq("bp_rd_en", 64'(fifo_rd_en), 64'd0);
        cycles(5);
        check_eq("bp_data_hold", 64'(m_data), 64'h03020100);
        check_eq("bp_pops_hold", 64'(rd_ptr), 64'd16);
        m_ready = 1'b1;
        wait_beats("bp_beats", 5, 40);
        cycles(3);
        check_eq("bp_beat2", 64'(beat_data[2]), 64'h03020100);
        check_eq("bp_beat3", 64'(beat_data[3]), 64'h07060504);
        check_eq("bp_beat4", 64'(beat_data[4]), 64'h0B0A0908);
        check_eq("bp_pops_total", 64'(rd_ptr), 64'd20);
        check_eq("bp_idle", 64'(busy), 64'd0);

        // Partial flush.
        push(8'h10);
        push(8'h11);
        push(8'h12);
        cycles(6);
        check_eq("part_pops", 64'(rd_ptr), 64'd23);
        check_eq("part_no_beat", 64'(m_valid), 64'd0);
        check_eq("part_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge rd_clk);
        flush = 1'b0;
        wait_beats("part_beats", 6, 20);
        cycles(2);
        check_eq("part_data", 64'(beat_data[5]), 64'h00121110);
        check_eq("part_keep", 64'(beat_keep[5]), 64'h7);
        check_eq("part_idle", 64'(busy), 64'd0);

        // Flush with nothing accumulated.
        flush = 1'b1;
        @(negedge rd_clk);
        flush = 1'b0;
        check_eq("fe_drain_busy", 64'(busy), 64'd1);
        @(negedge rd_clk);
        check_eq("fe_idle", 64'(busy), 64'd0);
        check_eq("fe_no_beat", 64'(beat_cnt), 64'd6);

        // Flush in the same cycle as a pop.
        push(8'h20);
        push(8'h21);
        push(8'h22);
        @(negedge rd_clk);
        check_eq("race_rd_en", 64'(fifo_rd_en), 64'd1);
        flush = 1'b1;
        @(negedge rd_clk);
        flush = 1'b0;
        check_eq("race_drain_rd_en", 64'(fifo_rd_en), 64'd0);
        check_eq("race_pops", 64'(rd_ptr), 64'd25);
        @(negedge rd_clk);
        check_eq("race_drain_rd_en2", 64'(fifo_rd_en), 64'd0);
        wait_beats("race_beats", 7, 20);
        check_eq("race_data", 64'(beat_data[6]), 64'h00002120);
        check_eq("race_keep", 64'(beat_keep[6]), 64'h3);
        cycles(4);
        check_eq("race_resume_pops", 64'(rd_ptr), 64'd26);
        check_eq("race_resume_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge rd_clk);
        flush = 1'b0;
        wait_beats("race_tail_beats", 8, 20);
        check_eq("race_tail_data", 64'(beat_data[7]), 64'h00000022);
        check_eq("race_tail_keep", 64'(beat_keep[7]), 64'h1);

        // Reset with a held beat and two lanes accumulated.
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(8'(8'h30 + i));
        cycles(12);
        check_eq("mr_valid", 64'(m_valid), 64'd1);
        check_eq("mr_data", 64'(m_data), 64'h33323130);
        check_eq("mr_pops", 64'(rd_ptr), 64'd32);
        rst_glb = 1'b1;
        @(negedge rd_clk);
        check_eq("mr_valid_clr", 64'(m_valid), 64'd0);
        check_eq("mr_keep_clr", 64'(m_keep), 64'd0);
        check_eq("mr_data_clr", 64'(m_data), 64'd0);
        check_eq("mr_busy_clr", 64'(busy), 64'd0);
        rst_glb = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(8'(8'h40 + i));
        wait_beats("mr_beats", 9, 30);
        check_eq("mr_new_data", 64'(beat_data[8]), 64'h43424140);
        check_eq("mr_new_keep", 64'(beat_keep[8]), 64'hF);
        check_eq("mr_new_pops", 64'(rd_ptr), 64'd36);
        check_eq("pop_while_empty", 64'(bad_pop), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
